// File: rtl/router_pkg.sv
// Shared definitions for the router memory-side blocks.
//   ADDR_WIDTH / AURORA_DATA_WIDTH : default packet-buffer geometry
//   state_e                        : burst FSM encoding
//   slot_of()                      : (requester, direction) -> arbitration slot
package router_pkg;

    localparam int ADDR_WIDTH        = 10;
    localparam int AURORA_DATA_WIDTH = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Writes sit in the even slot so they precede reads of the same requester.
    function automatic int slot_of(input int req, input logic is_wr);
        return 2 * req + (is_wr ? 0 : 1);
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req   : N request bits
//   ptr   : slot where the search starts (wraps past N-1)
//   found : at least one request is set
//   idx   : first set slot at or after ptr
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int c;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port packet BRAM between NUM_REQ
// router controllers. Round-robin over 2*NUM_REQ slots (write/read per
// requester), grant held for a BURST_LEN-beat burst with incrementing
// addresses, read data returned with a per-requester valid strobe.
//   clk, rst                 : clock, synchronous active-high reset
//   read_req / write_req     : per-requester level requests
//   req_src_addr/req_dst_addr: packed per-requester read/write base addresses
//   wr_data                  : packed per-requester write beat data
//   read_gnt / write_gnt     : one-hot per-beat grants
//   rd_data / rd_valid       : read return data and one-hot owner strobe
//   busy                     : burst in progress
//   mem_*                    : BRAM port (mem_rdata has RD_LATENCY cycles)
module mem_access_arbiter #(
    parameter int NUM_REQ           = 2,
    parameter int ADDR_WIDTH        = router_pkg::ADDR_WIDTH,
    parameter int AURORA_DATA_WIDTH = router_pkg::AURORA_DATA_WIDTH,
    parameter int BURST_LEN         = 3,
    parameter int RD_LATENCY        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   read_req,
    input  logic [NUM_REQ-1:0]                   write_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_src_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_dst_addr,
    input  logic [NUM_REQ*AURORA_DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]                   read_gnt,
    output logic [NUM_REQ-1:0]                   write_gnt,
    output logic [AURORA_DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]                   rd_valid,
    output logic                                 busy,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [AURORA_DATA_WIDTH-1:0]         mem_wdata,
    input  logic [AURORA_DATA_WIDTH-1:0]         mem_rdata
);

    import router_pkg::*;

    localparam int NSLOT = 2 * NUM_REQ;
    localparam int SW    = $clog2(NSLOT);
    localparam int OW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW    = $clog2(BURST_LEN + 1);

    typedef struct packed {
        logic [SW-1:0]         slot;
        logic [ADDR_WIDTH-1:0] base;
    } burst_ctx_t;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        src_v, dst_v;
    logic [NUM_REQ-1:0][AURORA_DATA_WIDTH-1:0] wdat_v;
    logic [NSLOT-1:0]                          slot_req;

    assign src_v  = req_src_addr;
    assign dst_v  = req_dst_addr;
    assign wdat_v = wr_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot_req[slot_of(i, 1'b1)] = write_req[i];
        assign slot_req[slot_of(i, 1'b0)] = read_req[i];
    end

    state_e          state;
    burst_ctx_t      ctx;
    logic [SW-1:0]   rr_ptr;
    logic [BW-1:0]   beat;

    logic                  pick_found;
    logic [SW-1:0]         pick_idx;
    logic [OW-1:0]         pick_owner, cur_owner;
    logic                  pick_wr;
    logic [ADDR_WIDTH-1:0] pick_base;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [SW-1:0]         next_slot;
    logic                  burst_stop;

    rr_picker #(.N(NSLOT)) u_pick (
        .req   (slot_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_owner = OW'(pick_idx >> 1);
    assign pick_wr    = ~pick_idx[0];
    assign pick_base  = pick_wr ? dst_v[pick_owner] : src_v[pick_owner];
    assign pick_oh    = NUM_REQ'(1) << pick_owner;
    assign cur_owner  = OW'(ctx.slot >> 1);
    assign next_slot  = (ctx.slot == SW'(NSLOT - 1)) ? '0 : ctx.slot + 1'b1;
    // A dropped request ends the burst exactly like the last beat does.
    assign burst_stop = !slot_req[ctx.slot] || (beat == BW'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctx       <= '0;
            rr_ptr    <= '0;
            beat      <= '0;
            read_gnt  <= '0;
            write_gnt <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BURST;
                        ctx.slot  <= pick_idx;
                        ctx.base  <= pick_base;
                        beat      <= '0;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_wr;
                        mem_addr  <= pick_base;
                        write_gnt <= pick_wr ? pick_oh : '0;
                        read_gnt  <= pick_wr ? '0 : pick_oh;
                    end
                end
                BURST: begin
                    if (burst_stop) begin
                        state     <= IDLE;
                        rr_ptr    <= next_slot;
                        busy      <= 1'b0;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        write_gnt <= '0;
                        read_gnt  <= '0;
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_addr <= ctx.base + ADDR_WIDTH'(beat + 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wdata = mem_we ? wdat_v[cur_owner] : '0;

    // Read-return tracker: one entry per read beat, aligned to BRAM latency.
    logic [RD_LATENCY-1:0]         vld_pipe;
    logic [RD_LATENCY-1:0][OW-1:0] own_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[0] <= mem_en & ~mem_we;
            own_pipe[0] <= cur_owner;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                own_pipe[k] <= own_pipe[k-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY-1] ? (NUM_REQ'(1) << own_pipe[RD_LATENCY-1]) : '0;
    assign rd_data  = vld_pipe[RD_LATENCY-1] ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  read_req, write_req;
    logic [19:0] req_src_addr, req_dst_addr;
    logic [127:0] wr_data;
    logic [1:0]  read_gnt, write_gnt, rd_valid;
    logic [63:0] rd_data, mem_wdata, mem_rdata;
    logic        busy, mem_en, mem_we;
    logic [9:0]  mem_addr;

    int nvec = 0;
    int nerr = 0;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .read_req(read_req), .write_req(write_req),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .wr_data(wr_data),
        .read_gnt(read_gnt), .write_gnt(write_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model, 1-cycle read latency; data tags the address it came from.
    function automatic logic [63:0] rdat(input logic [9:0] a);
        return 64'hD000_0000_0000_0000 | {54'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rdat(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt"}, {write_gnt, read_gnt}, 4'b0000);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " mem_en"}, mem_en, 1'b0);
        chk({tag, " rd_valid"}, rd_valid, 2'b00);
    endtask

    logic [3:0]  ord_gnt [5];
    logic [9:0]  ord_base[5];

    initial begin
        rst = 1'b1; read_req = '0; write_req = '0;
        req_src_addr = '0; req_dst_addr = '0; wr_data = '0;
        tick(); tick();

        // reset state
        chk_quiet("reset");
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset mem_addr", mem_addr, 10'd0);
        chk("reset mem_wdata", mem_wdata, 64'd0);
        chk("reset rd_data", rd_data, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk_quiet("idle"); end

        // single read burst at 100
        read_req = 2'b01; req_src_addr[9:0] = 10'd100;
        tick();
        chk("rd b0 gnt", {write_gnt, read_gnt}, 4'b0001);
        chk("rd b0 addr", mem_addr, 10'd100);
        chk("rd b0 we", mem_we, 1'b0);
        chk("rd b0 busy", busy, 1'b1);
        chk("rd b0 rv", rd_valid, 2'b00);
        tick();
        chk("rd b1 addr", mem_addr, 10'd101);
        chk("rd b1 rv", rd_valid, 2'b01);
        chk("rd b1 data", rd_data, rdat(10'd100));
        tick();
        chk("rd b2 addr", mem_addr, 10'd102);
        chk("rd b2 gnt", read_gnt, 2'b01);
        chk("rd b2 data", rd_data, rdat(10'd101));
        tick();
        chk("rd end gnt", {write_gnt, read_gnt}, 4'b0000);
        chk("rd end busy", busy, 1'b0);
        chk("rd end rv", rd_valid, 2'b01);
        chk("rd end data", rd_data, rdat(10'd102));
        tick();
        chk("rd again gnt", read_gnt, 2'b01);
        chk("rd again addr", mem_addr, 10'd100);

        // abort after first beat; write of requester 1 waits in slot 2
        read_req = 2'b00;
        write_req = 2'b10; req_dst_addr[19:10] = 10'd1023;
        wr_data[127:64] = 64'hAAAA_0000_0000_000A;
        tick();
        chk("abort gnt", {write_gnt, read_gnt}, 4'b0000);
        chk("abort busy", busy, 1'b0);
        chk("abort rv", rd_valid, 2'b01);
        chk("abort data", rd_data, rdat(10'd100));
        tick();
        chk("wr b0 gnt", {write_gnt, read_gnt}, 4'b1000);
        chk("wr b0 addr", mem_addr, 10'd1023);
        chk("wr b0 we", mem_we, 1'b1);
        chk("wr b0 wdata", mem_wdata, 64'hAAAA_0000_0000_000A);
        chk("abort no 2nd rv", rd_valid, 2'b00);
        wr_data[127:64] = 64'hBBBB_0000_0000_000B;
        tick();
        chk("wr b1 addr wrap", mem_addr, 10'd0);
        chk("wr b1 wdata", mem_wdata, 64'hBBBB_0000_0000_000B);
        chk("wr b1 gnt", write_gnt, 2'b10);
        wr_data[127:64] = 64'hCCCC_0000_0000_000C;
        tick();
        chk("wr b2 addr", mem_addr, 10'd1);
        chk("wr b2 wdata", mem_wdata, 64'hCCCC_0000_0000_000C);
        chk("wr b2 rv", rd_valid, 2'b00);
        write_req = 2'b00;
        tick();
        chk_quiet("wr end");

        // full contention from reset
        rst = 1'b1;
        read_req = 2'b11; write_req = 2'b11;
        req_dst_addr = {10'd400, 10'd200};
        req_src_addr = {10'd500, 10'd300};
        tick();
        chk_quiet("ct reset");
        rst = 1'b0;
        ord_gnt  = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100};
        ord_base = '{10'd200, 10'd300, 10'd400, 10'd500, 10'd200};
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk($sformatf("ct b%0d k%0d gnt", b, k), {write_gnt, read_gnt}, ord_gnt[b]);
                chk($sformatf("ct b%0d k%0d addr", b, k), mem_addr, ord_base[b] + 10'(k));
            end
            tick();
            chk($sformatf("ct b%0d dead", b), {write_gnt, read_gnt}, 4'b0000);
        end

        // reset in the middle of a read burst
        rst = 1'b1; read_req = 2'b00; write_req = 2'b00;
        tick();
        rst = 1'b0; read_req = 2'b01;
        tick();
        chk("mr b0 addr", mem_addr, 10'd300);
        tick();
        chk("mr b1 rv", rd_valid, 2'b01);
        rst = 1'b1; read_req = 2'b00;
        tick();
        chk_quiet("mr reset");
        chk("mr mem_addr", mem_addr, 10'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk_quiet("mr after"); end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
